// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback slice: widths, load types, FSM states.
// The optional misaligned-load fault path is enabled with the WB_MISALIGN_EN macro.
package rf_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/rf_load_align.sv
// Combinational load formatter: selects the byte/half lane, extends it, and flags misalignment.
// Undefined load types behave as LW for both data and alignment.
module rf_load_align
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            misaligned_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel      = rdata_i[{addr_lo_i, 3'b000} +: 8];
        halfSel      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o       = rdata_i;
        misaligned_o = 1'b0;
        case (funct3_i)
            F3_LB: data_o = {{(XLEN-8){byteSel[7]}}, byteSel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byteSel};
            F3_LH: begin
                data_o       = {{(XLEN-16){halfSel[15]}}, halfSel};
                misaligned_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o       = {{(XLEN-16){1'b0}}, halfSel};
                misaligned_o = addr_lo_i[0];
            end
            default: begin
                data_o       = rdata_i;
                misaligned_o = (addr_lo_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// Writeback stage merging ALU results and single-outstanding load responses into one RF write port.
// Define WB_MISALIGN_EN to suppress misaligned LH/LHU/LW writes and raise misalign_err.
module rf_writeback
    import rf_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [RADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]    alu_result,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [RADDR_W-1:0] ld_rd,
    input  logic [2:0]         ld_funct3,
    input  logic [1:0]         ld_addr_lo,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic [XLEN-1:0]    w_data,
    output logic [RADDR_W-1:0] w_addr,
    output logic               w_ena,
`ifdef WB_MISALIGN_EN
    output logic               misalign_err,
`endif
    output logic               load_busy
);

    wb_state_e          state_q, state_d;
    logic [RADDR_W-1:0] ldRd_q;
    logic [2:0]         ldFunct3_q;
    logic [1:0]         ldAddrLo_q;
    logic               wEna_q, wEna_d;
    logic [RADDR_W-1:0] wAddr_q, wAddr_d;
    logic [XLEN-1:0]    wData_q, wData_d;
    logic [XLEN-1:0]    loadData;
    logic               ldFire, aluFire, respFire;
`ifdef WB_MISALIGN_EN
    logic               loadMisaligned;
    logic               misalignErr_q;
`else
    logic               unusedMisaligned;
`endif

    rf_load_align #(.XLEN(XLEN)) u_align (
        .funct3_i     (ldFunct3_q),
        .addr_lo_i    (ldAddrLo_q),
        .rdata_i      (mem_rdata),
        .data_o       (loadData),
`ifdef WB_MISALIGN_EN
        .misaligned_o (loadMisaligned)
`else
        .misaligned_o (unusedMisaligned)
`endif
    );

    assign respFire = (state_q == WAIT) && mem_rvalid;
    assign ldFire   = ld_valid && ld_ready;
    assign aluFire  = alu_valid && alu_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ldFire) state_d = WAIT;
            WAIT: if (mem_rvalid) state_d = ldFire ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // An ALU write to the pending load's rd must wait, or the older load would overwrite it.
    always_comb begin
        ld_ready  = 1'b1;
        alu_ready = 1'b1;
        load_busy = 1'b0;
        if (state_q == WAIT) begin
            ld_ready  = mem_rvalid;
            alu_ready = !mem_rvalid && !((alu_rd == ldRd_q) && (alu_rd != '0));
            load_busy = 1'b1;
        end
    end

    always_comb begin
        wEna_d  = 1'b0;
        wAddr_d = wAddr_q;
        wData_d = wData_q;
        if (respFire) begin
`ifdef WB_MISALIGN_EN
            wEna_d = (ldRd_q != '0) && !loadMisaligned;
`else
            wEna_d = (ldRd_q != '0);
`endif
            wAddr_d = ldRd_q;
            wData_d = loadData;
        end else if (aluFire) begin
            wEna_d  = (alu_rd != '0);
            wAddr_d = alu_rd;
            wData_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ldRd_q     <= '0;
            ldFunct3_q <= '0;
            ldAddrLo_q <= '0;
            wEna_q     <= 1'b0;
            wAddr_q    <= '0;
            wData_q    <= '0;
        end else begin
            if (ldFire) begin
                ldRd_q     <= ld_rd;
                ldFunct3_q <= ld_funct3;
                ldAddrLo_q <= ld_addr_lo;
            end
            wEna_q  <= wEna_d;
            wAddr_q <= wAddr_d;
            wData_q <= wData_d;
        end
    end

`ifdef WB_MISALIGN_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            misalignErr_q <= 1'b0;
        end else begin
            misalignErr_q <= respFire && loadMisaligned;
        end
    end

    assign misalign_err = misalignErr_q;
`endif

    assign w_ena  = wEna_q;
    assign w_addr = wAddr_q;
    assign w_data = wData_q;

endmodule

// File: tb/tb_rf_writeback.sv
// Scoreboard bench for rf_writeback: directed scenarios plus randomized traffic against a transaction model.
// Compiling with WB_MISALIGN_EN also checks the misalign_err pulses and write suppression.
module tb_rf_writeback;
    import rf_pkg::*;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    logic               clk = 1'b0;
    logic               resetn;
    logic               alu_valid, alu_ready;
    logic [RADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]    alu_result;
    logic               ld_valid, ld_ready;
    logic [RADDR_W-1:0] ld_rd;
    logic [2:0]         ld_funct3;
    logic [1:0]         ld_addr_lo;
    logic               mem_rvalid;
    logic [XLEN-1:0]    mem_rdata;
    logic [XLEN-1:0]    w_data;
    logic [RADDR_W-1:0] w_addr;
    logic               w_ena;
    logic               load_busy;
`ifdef WB_MISALIGN_EN
    logic               misalign_err;
    int                 misQ[$];
`endif

    rf_writeback #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_result   (alu_result),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_funct3    (ld_funct3),
        .ld_addr_lo   (ld_addr_lo),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .w_data       (w_data),
        .w_addr       (w_addr),
        .w_ena        (w_ena),
`ifdef WB_MISALIGN_EN
        .misalign_err (misalign_err),
`endif
        .load_busy    (load_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        logic [4:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t expQ[$];
    int  vectors     = 0;
    int  miscompares = 0;

    bit         pend = 1'b0;
    logic [4:0] pRd;
    logic [2:0] pF3;
    logic [1:0] pLo;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fmtLoad(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
        longint v;
        case (f3)
            3'b000, 3'b100: begin
                v = longint'((w >> (lo * 8)) & 32'hFF);
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                v = longint'((w >> (lo[1] * 16)) & 32'hFFFF);
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    function automatic bit isMisaligned(input logic [2:0] f3, input logic [1:0] lo);
        if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
        if (f3 == 3'b001 || f3 == 3'b101) return lo[0];
        return lo != 2'b00;
    endfunction

    // Monitor: every w_ena pulse must match the oldest expected write, in the expected cycle.
    always @(negedge clk) begin
        wr_t e;
        if (w_ena) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious w_ena", {31'd0, w_ena}, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("write cycle", cyc, e.cycle);
                checkOutput("w_addr", {27'd0, w_addr}, {27'd0, e.addr});
                checkOutput("w_data", w_data, e.data);
            end
        end
`ifdef WB_MISALIGN_EN
        begin
            bit expMis;
            expMis = (misQ.size() > 0) && (misQ[0] == cyc);
            if (expMis) void'(misQ.pop_front());
            if (misalign_err || expMis) checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, expMis});
        end
`endif
    end

    // One cycle of stimulus, issued just after a falling edge; the model decides what gets accepted.
    task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [31:0] ares,
                                 input bit lv, input logic [4:0] lrd, input logic [2:0] f3,
                                 input logic [1:0] lo, input bit rv, input logic [31:0] rdata);
        bit expLd, expAlu, respNow;
        alu_valid  = av;
        alu_rd     = ard;
        alu_result = ares;
        ld_valid   = lv;
        ld_rd      = lrd;
        ld_funct3  = f3;
        ld_addr_lo = lo;
        mem_rvalid = rv;
        mem_rdata  = rdata;
        #1;
        respNow = pend && rv;
        expLd   = !pend || rv;
        expAlu  = !respNow && !(pend && ard == pRd && ard != 5'd0);
        checkOutput("load_busy", {31'd0, load_busy}, {31'd0, pend});
        checkOutput("ld_ready", {31'd0, ld_ready}, {31'd0, expLd});
        checkOutput("alu_ready", {31'd0, alu_ready}, {31'd0, expAlu});
        if (respNow) begin
`ifdef WB_MISALIGN_EN
            if (isMisaligned(pF3, pLo)) misQ.push_back(cyc + 1);
            else if (pRd != 5'd0) expQ.push_back('{cyc + 1, pRd, fmtLoad(pF3, pLo, rdata)});
`else
            if (pRd != 5'd0) expQ.push_back('{cyc + 1, pRd, fmtLoad(pF3, pLo, rdata)});
`endif
            pend = 1'b0;
        end
        if (av && expAlu && ard != 5'd0) expQ.push_back('{cyc + 1, ard, ares});
        if (lv && expLd) begin
            pend = 1'b1;
            pRd  = lrd;
            pF3  = f3;
            pLo  = lo;
        end
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        alu_valid  = 0;
        ld_valid   = 0;
        mem_rvalid = 0;
        resetn     = 0;
        @(negedge clk);
        resetn = 1;
        pend   = 1'b0;
        checkOutput("reset w_ena", {31'd0, w_ena}, 32'd0);
        checkOutput("reset w_addr", {27'd0, w_addr}, 32'd0);
        checkOutput("reset w_data", w_data, 32'd0);
        checkOutput("reset load_busy", {31'd0, load_busy}, 32'd0);
    endtask

    initial begin
        resetn     = 0;
        alu_valid  = 0;
        alu_rd     = 0;
        alu_result = 0;
        ld_valid   = 0;
        ld_rd      = 0;
        ld_funct3  = 0;
        ld_addr_lo = 0;
        mem_rvalid = 0;
        mem_rdata  = 0;
        repeat (2) @(negedge clk);
        doReset();

        applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        checkOutput("alu w_ena", {31'd0, w_ena}, 32'd1);
        checkOutput("alu w_data", w_data, 32'hDEADBEEF);
        idleCycle();
        checkOutput("alu pulse end", {31'd0, w_ena}, 32'd0);

        applyStimulus(0, 0, 0, 1, 3, 3'b000, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12F45678);
        checkOutput("LB data", w_data, 32'hFFFFFFF4);
        applyStimulus(0, 0, 0, 1, 3, 3'b100, 2, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h12F45678);
        checkOutput("LBU data", w_data, 32'h000000F4);
        checkOutput("held w_addr", {27'd0, w_addr}, 32'd3);

        applyStimulus(0, 0, 0, 1, 4, 3'b010, 0, 0, 0);
        applyStimulus(1, 7, 32'hA5A5_0007, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
        applyStimulus(1, 7, 32'hA5A5_0007, 0, 0, 0, 0, 0, 0);
        idleCycle();

        applyStimulus(0, 0, 0, 1, 9, 3'b001, 2, 0, 0);
        applyStimulus(1, 9, 32'h0000_0909, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 10, 32'h0000_1010, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 9, 32'h0000_0909, 0, 0, 0, 0, 1, 32'h8001_7FFF);
        applyStimulus(1, 9, 32'h0000_0909, 0, 0, 0, 0, 0, 0);
        idleCycle();

        applyStimulus(1, 0, 32'h1111_1111, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 3'b010, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
        idleCycle();

        applyStimulus(0, 0, 0, 1, 12, 3'b010, 0, 0, 0);
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);
        idleCycle();

`ifdef WB_MISALIGN_EN
        applyStimulus(0, 0, 0, 1, 6, 3'b010, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h4444_4444);
        idleCycle();
`endif

        for (int i = 0; i < 400; i++) begin
            bit rv;
            rv = pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                          $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), rv, $urandom);
        end
        repeat (3) idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, pend, $urandom);
        repeat (3) idleCycle();
        checkOutput("writes outstanding", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Writeback stage directly upstream of the register file. It drives the register file's w_data / w_addr / w_ena inputs.
- It merges two producers:
  - single-cycle ALU results;
  - variable-latency memory load responses.
- Load responses are aligned and sign- or zero-extended, writes to x0 are suppressed, and both producers are arbitrated with valid/ready handshakes.
- One load is outstanding at most. ALU writes proceed under a pending load unless they would break write ordering.

Parameters:
- XLEN, 32, data width of results and register file data.
- RADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous reset, active low.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU result accepted this cycle (alu_valid && alu_ready).
- alu_rd  in  RADDR_W  ALU destination register.
- alu_result  in  XLEN  ALU result value.
- ld_valid  in  1  load issue offered.
- ld_ready  out  1  load issue accepted this cycle.
- ld_rd  in  RADDR_W  load destination register.
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ld_addr_lo  in  2  byte address bits [1:0] of the load.
- mem_rvalid  in  1  memory read data valid; single-cycle pulse.
- mem_rdata  in  XLEN  raw aligned memory word.
- w_data  out  XLEN  register file write data.
- w_addr  out  RADDR_W  register file write index.
- w_ena  out  1  register file write enable.
- load_busy  out  1  a load is outstanding.

Behaviour:
- Reset (resetn low at an edge):
  - w_ena=0, w_addr=0, w_data=0, load_busy=0, misalign_err=0;
  - FSM goes to IDLE and any pending load is discarded.
  - A mem_rvalid arriving after reset while in IDLE is ignored.
- FSM states:
  - IDLE: ld_ready=1. On an ld handshake, latch rd, funct3 and addr_lo, then go to WAIT.
  - WAIT: ld_ready=mem_rvalid, so a back-to-back issue is allowed in the response cycle. On mem_rvalid, produce the load write. Then:
    - new ld handshake in the same cycle: stay in WAIT with the new load latched;
    - otherwise: go to IDLE.
- load_busy = (state==WAIT).
- Outputs are registered:
  - a write accepted or produced in cycle N appears with w_ena=1 in cycle N+1;
  - w_ena is a single-cycle pulse per write.
- Arbitration:
  - A load response (mem_rvalid in WAIT) has priority.
  - alu_ready=0 in any cycle where mem_rvalid is high in WAIT.
- Ordering hazard: in WAIT, alu_ready=0 when alu_rd equals the pending load rd and alu_rd≠0. This holds until the response is written.
- Otherwise alu_ready=1.
- x0 writes:
  - The handshake completes normally.
  - w_ena stays 0 in the following cycle. w_addr and w_data are don't-care.
- Load formatting:
  - Byte lane = addr_lo; half lane = addr_lo[1].
  - LB / LH sign-extend; LBU / LHU zero-extend.
  - LW passes mem_rdata unchanged.
  - Undefined funct3 values (011, 110, 111) are treated as LW.
- Half/word loads with misaligned addr_lo use lane addr_lo[1] (half) or the full word (LW), with no fault, unless the optional feature is enabled.
- When idle, w_addr and w_data hold their last value.

Optional Feature:
- Macro: WB_MISALIGN_EN.
- Defined:
  - Adds output misalign_err (1 bit, registered; reset value 0).
  - A load response whose latched type is LH/LHU with addr_lo[0]=1, or LW with addr_lo≠0, suppresses the write (w_ena=0 next cycle).
  - misalign_err pulses for one cycle at N+1.
- Undefined: the port is absent and misaligned loads write as described in Behaviour.

Decomposition:
- Shared package rf_pkg:
  - XLEN and RADDR_W defaults;
  - load funct3 localparams (LB, LH, LW, LBU, LHU);
  - FSM state enum {IDLE, WAIT}.
- Natural sub-module: rf_load_align, a purely combinational unit.
  - Inputs: funct3, addr_lo, rdata.
  - Outputs: formatted data and a misaligned flag.
  - Instantiated once.

Test Plan:
- ALU write: alu_valid, alu_rd=5, alu_result=32'hDEADBEEF → alu_ready=1; next cycle w_ena=1, w_addr=5, w_data=32'hDEADBEEF. Then w_ena=0.
- Sign handling: load LB rd=3, addr_lo=2; mem_rvalid with rdata=32'h12F45678 → next cycle w_addr=3, w_data=32'hFFFFFFF4. Repeating with LBU gives 32'h000000F4.
- Collision: in WAIT, alu_valid rd=7 and mem_rvalid in the same cycle → alu_ready=0; load written at N+1; ALU written at N+2.
- WAW stall: load pending to rd=9; ALU to rd=9 → alu_ready=0 until the response; ALU to rd=10 during the wait → accepted and written immediately.
- x0 suppression: ALU rd=0 and load rd=0 → both handshakes complete; w_ena stays 0 throughout.
- Reset mid-load: issue load, assert resetn=0 for one cycle, then mem_rvalid → load_busy=0 and no w_ena. With WB_MISALIGN_EN, LW with addr_lo=1 → misalign_err pulse and no write.
